// File: rtl/tune_pwm_capture.sv
// Buzzer PWM receiver: recovers period parameter, high time and loudness
// class from an asynchronous PWM input, with a silence timeout.
module tune_pwm_capture #(
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_CYCLES  = 1048575
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_param,
  output logic [CNT_W-1:0] high_cycles,
  output logic [1:0]       loudness,
  output logic             valid,
  output logic             silent
);

  localparam int XW = CNT_W + 4;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_q;
  logic                   rise_q;
  logic                   fall_q;
  logic [CNT_W-1:0]       hcnt_q;
  logic [CNT_W-1:0]       pcnt_q;
  logic [CNT_W-1:0]       period_q;
  logic [CNT_W-1:0]       high_q;
  logic [1:0]             loud_q;
  logic                   valid_q;
  logic                   silent_q;

  logic                   s;
  logic [XW-1:0]          h16;
  logic [XW-1:0]          p1;
  logic [XW-1:0]          p3;
  logic [XW-1:0]          p5;
  logic [XW-1:0]          p7;
  logic [1:0]             loud_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Edge strobes are registered so every edge reaches the FSM
  // with the same fixed delay from pwm_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_q    <= s;
      rise_q <= s & ~s_q;
      fall_q <= ~s & s_q;
    end
  end

  assign h16 = XW'(hcnt_q) << 4;
  assign p1  = XW'(pcnt_q);
  assign p3  = (p1 << 1) + p1;
  assign p5  = (p1 << 2) + p1;
  assign p7  = (p1 << 3) - p1;

  always_comb begin
    loud_d = 2'b00;
    if (h16 >= p7) begin
      loud_d = 2'b11;
    end else if (h16 >= p5) begin
      loud_d = 2'b10;
    end else if (h16 >= p3) begin
      loud_d = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      loud_q   <= 2'b00;
      valid_q  <= 1'b0;
      silent_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      if (!en) begin
        state_q <= S_IDLE;
        hcnt_q  <= '0;
        pcnt_q  <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (rise_q) begin
              state_q <= S_HIGH;
              hcnt_q  <= ONE;
              pcnt_q  <= ONE;
            end
          end
          S_HIGH: begin
            if (pcnt_q == MAX_C) begin
              state_q  <= S_IDLE;
              hcnt_q   <= '0;
              pcnt_q   <= '0;
              silent_q <= 1'b1;
            end else if (fall_q) begin
              state_q <= S_LOW;
              pcnt_q  <= pcnt_q + ONE;
            end else begin
              hcnt_q <= hcnt_q + ONE;
              pcnt_q <= pcnt_q + ONE;
            end
          end
          S_LOW: begin
            // A closing rise beats a coincident timeout.
            if (rise_q) begin
              period_q <= pcnt_q - ONE;
              high_q   <= hcnt_q;
              loud_q   <= loud_d;
              valid_q  <= 1'b1;
              silent_q <= 1'b0;
              state_q  <= S_HIGH;
              hcnt_q   <= ONE;
              pcnt_q   <= ONE;
            end else if (pcnt_q == MAX_C) begin
              state_q  <= S_IDLE;
              hcnt_q   <= '0;
              pcnt_q   <= '0;
              silent_q <= 1'b1;
            end else begin
              pcnt_q <= pcnt_q + ONE;
            end
          end
          default: begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign period_param = period_q;
  assign high_cycles  = high_q;
  assign loudness     = loud_q;
  assign valid        = valid_q;
  assign silent       = silent_q;

endmodule
